path_result_reader: RTL and testbench

Path-result reader for the shortest-path engine. After a run, it walks the output memory that the datapath wrote, starting at a base address. It parses each result record (destination, predecessor chain, distance, terminator) and streams the result as bytes over a valid/ready interface to the host-side link. It is the consumer end of the datapath's output-memory write protocol.

---
 rtl/path_result_reader_if.sv | 27 ++
 rtl/path_result_reader.sv | 159 +++++++++++++++
 tb/tb_path_result_reader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/path_result_reader_if.sv
// Output-memory read port and host byte stream
// bundled between the path reader and its peers.
interface path_result_reader_if #(
  parameter int ADDR_W = 14
);
  logic              mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic [15:0]       mem_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_read, mem_address,
    input  mem_data,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_read, mem_address,
    output mem_data,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/path_result_reader.sv
// Walks shortest-path result records in output memory
// and streams them as bytes. Option: PATH_READER_STATS_EN.
module path_result_reader #(
  parameter int ADDR_W    = 14,
  parameter int MAX_WORDS = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_address,
  path_result_reader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        record_count
);

  typedef enum logic [2:0] {
    IDLE, RD, CAP, EMIT, DONE
  } state_t;

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WORDS);

  state_t        state;
  logic [15:0]   held;
  logic          held_v;
  logic          first;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] cnt_nx;
  logic [7:0]    q1;
  logic          two;
  logic          term;

  assign term   = bus.mem_data == 16'hFFFF;
  assign cnt_nx = word_cnt + 1'b1;

  // Read/capture/emit sequencer with registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      bus.mem_read    <= 1'b0;
      bus.mem_address <= '0;
      bus.out_data    <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_last    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      held            <= '0;
      held_v          <= 1'b0;
      first           <= 1'b0;
      word_cnt        <= '0;
      q1              <= '0;
      two             <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            bus.mem_address <= base_address;
            first           <= 1'b1;
            held_v          <= 1'b0;
            word_cnt        <= '0;
            error           <= 1'b0;
            busy            <= 1'b1;
            bus.mem_read    <= 1'b1;
            state           <= RD;
          end
        end
        RD: begin
          bus.mem_read <= 1'b0;
          state        <= CAP;
        end
        CAP: begin
          bus.mem_address <= bus.mem_address + 1'b1;
          word_cnt        <= cnt_nx;
          if (first && term) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (!term && cnt_nx == LIMIT) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (first) begin
            bus.out_data  <= bus.mem_data[7:0];
            bus.out_valid <= 1'b1;
            bus.out_last  <= 1'b0;
            two           <= 1'b0;
            first         <= 1'b0;
            state         <= EMIT;
          end else if (term) begin
            if (!held_v) error <= 1'b1;
            bus.out_data  <= held_v ? held[15:8] : 8'hFF;
            q1            <= held_v ? held[7:0] : 8'hFF;
            two           <= 1'b1;
            bus.out_valid <= 1'b1;
            bus.out_last  <= 1'b0;
            first         <= 1'b1;
            held_v        <= 1'b0;
            word_cnt      <= '0;
            state         <= EMIT;
          end else if (held_v) begin
            if (held[15:8] != 8'h00) error <= 1'b1;
            bus.out_data  <= held[7:0];
            bus.out_valid <= 1'b1;
            bus.out_last  <= 1'b0;
            two           <= 1'b0;
            held          <= bus.mem_data;
            state         <= EMIT;
          end else begin
            held         <= bus.mem_data;
            held_v       <= 1'b1;
            bus.mem_read <= 1'b1;
            state        <= RD;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (two) begin
              bus.out_data <= q1;
              bus.out_last <= 1'b1;
              two          <= 1'b0;
            end else begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.mem_read  <= 1'b1;
              state         <= RD;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PATH_READER_STATS_EN
  logic rec_inc;
  assign rec_inc = state == CAP && !first && term;

  // Saturating count of records closed with out_last
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      record_count <= '0;
    end else if (state == IDLE && start) begin
      record_count <= '0;
    end else if (rec_inc && record_count != 8'hFF) begin
      record_count <= record_count + 1'b1;
    end
  end
`else
  assign record_count = '0;
`endif

endmodule

// File: tb/tb_path_result_reader.sv
// Directed vector bench for path_result_reader
// with a 1-cycle-latency memory model.
module tb_path_result_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] base_address = '0;
  logic        busy, done, error;
  logic [7:0]  record_count;

  path_result_reader_if #(.ADDR_W(14)) bus();

  path_result_reader #(
    .ADDR_W(14),
    .MAX_WORDS(64)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .base_address(base_address),
    .bus(bus),
    .busy(busy),
    .done(done),
    .error(error),
    .record_count(record_count)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:16383];

  always @(posedge clock)
    if (bus.mem_read) bus.mem_data <= mem[bus.mem_address];

  int vecs = 0;
  int fails = 0;
  logic [8:0] got[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [13:0]       base;
    int                nw;
    logic [0:7][15:0]  w;
    int                tog;
    int                poke;
    int                nb;
    logic [0:7][7:0]   b;
    logic [7:0]        lmask;
    logic              err;
    int                rc;
    int                done_cyc;
  } vec_t;

  vec_t tab[6];

  task automatic clear_mem();
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
  endtask

  task automatic load(input vec_t v);
    logic [13:0] a;
    clear_mem();
    for (int i = 0; i < v.nw; i++) begin
      a = v.base + 14'(i);
      mem[a] = v.w[i];
    end
  endtask

  // Start a read-out and gather accepted bytes
  task automatic collect(input logic [13:0] base,
                         input int tog,
                         input int poke,
                         output int done_c,
                         output int first_v,
                         output int nreads,
                         output bit wrapped);
    int cyc;
    bit pend;
    logic [8:0] pv;
    logic [13:0] last_a;
    done_c = 0;
    first_v = 0;
    nreads = 0;
    wrapped = 0;
    pend = 0;
    pv = '0;
    last_a = '0;
    got.delete();
    @(negedge clock);
    base_address = base;
    start = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (cyc < 3000) begin
      if (cyc == poke) begin
        start = 1'b1;
        base_address = 14'h0200;
      end else begin
        start = 1'b0;
      end
      bus.out_ready = (tog != 0) ? cyc[0] : 1'b1;
      #1;
      if (cyc == 1) begin
        chk("busy_t1", 32'(busy), 1);
        chk("read_t1", 32'(bus.mem_read), 1);
      end
      if (pend)
        chk("stall_hold",
            {bus.out_valid, bus.out_last, bus.out_data},
            {1'b1, pv});
      if (bus.mem_read) begin
        if (nreads > 0 && last_a == 14'h3FFF &&
            bus.mem_address == 14'h0000)
          wrapped = 1;
        last_a = bus.mem_address;
        nreads++;
      end
      if (bus.out_valid && first_v == 0) first_v = cyc;
      if (bus.out_valid && bus.out_ready)
        got.push_back({bus.out_last, bus.out_data});
      pend = bus.out_valid && !bus.out_ready;
      pv = {bus.out_last, bus.out_data};
      if (done) begin
        chk("done_vs_valid", 32'(bus.out_valid), 0);
        done_c = cyc;
        break;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    if (done_c == 0) chk("timeout", 0, 1);
  endtask

  task automatic run(input vec_t v, input string tag);
    int dc, fv, nr, rc;
    bit wr;
    load(v);
    collect(v.base, v.tog, v.poke, dc, fv, nr, wr);
    chk({tag, "_nbytes"}, 32'(got.size()), 32'(v.nb));
    for (int i = 0; i < v.nb; i++) begin
      if (i < got.size()) begin
        chk({tag, "_byte"}, 32'(got[i][7:0]), 32'(v.b[i]));
        chk({tag, "_last"}, 32'(got[i][8]), 32'(v.lmask[i]));
      end
    end
    chk({tag, "_error"}, 32'(error), 32'(v.err));
`ifdef PATH_READER_STATS_EN
    rc = v.rc;
`else
    rc = 0;
`endif
    chk({tag, "_rcount"}, 32'(record_count), 32'(rc));
    chk({tag, "_first_valid"}, 32'(fv),
        (v.nb > 0) ? 32'd3 : 32'd0);
    if (v.done_cyc != 0)
      chk({tag, "_done_cyc"}, 32'(dc), 32'(v.done_cyc));
    @(negedge clock);
    #1;
    chk({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int dc, fv, nr, k;
    bit wr;
    vec_t lim;

    tab[0] = '{base: 14'h0040, nw: 6,
      w: {16'h0005, 16'h0003, 16'h0001, 16'h0012,
          16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000},
      tog: 0, poke: 0, nb: 5,
      b: {8'h05, 8'h03, 8'h01, 8'h00,
          8'h12, 8'h00, 8'h00, 8'h00},
      lmask: 8'h10, err: 1'b0, rc: 1, done_cyc: 18};
    tab[1] = tab[0];
    tab[1].tog = 1;
    tab[1].poke = 5;
    tab[1].done_cyc = 0;
    tab[2] = '{base: 14'h0100, nw: 1,
      w: {16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
          16'h0000, 16'h0000, 16'h0000, 16'h0000},
      tog: 0, poke: 0, nb: 0, b: '0,
      lmask: 8'h00, err: 1'b0, rc: 0, done_cyc: 3};
    tab[3] = '{base: 14'h0200, nw: 3,
      w: {16'h0007, 16'hFFFF, 16'hFFFF, 16'h0000,
          16'h0000, 16'h0000, 16'h0000, 16'h0000},
      tog: 0, poke: 0, nb: 3,
      b: {8'h07, 8'hFF, 8'hFF, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00},
      lmask: 8'h04, err: 1'b1, rc: 1, done_cyc: 10};
    tab[4] = '{base: 14'h0300, nw: 8,
      w: {16'h0004, 16'h0020, 16'hFFFF, 16'h0006,
          16'h0002, 16'h0030, 16'hFFFF, 16'hFFFF},
      tog: 0, poke: 0, nb: 7,
      b: {8'h04, 8'h00, 8'h20, 8'h06,
          8'h02, 8'h00, 8'h30, 8'h00},
      lmask: 8'h44, err: 1'b0, rc: 2, done_cyc: 24};
    tab[5] = '{base: 14'h3FFD, nw: 5,
      w: {16'h0002, 16'h0103, 16'h0009, 16'hFFFF,
          16'hFFFF, 16'h0000, 16'h0000, 16'h0000},
      tog: 1, poke: 0, nb: 4,
      b: {8'h02, 8'h03, 8'h00, 8'h09,
          8'h00, 8'h00, 8'h00, 8'h00},
      lmask: 8'h08, err: 1'b1, rc: 1, done_cyc: 0};

    bus.out_ready = 1'b0;
    #1;
    chk("rst_state",
        {busy, done, error, bus.mem_read,
         bus.out_valid, bus.out_last},
        6'b0);
    chk("rst_addr", 32'(bus.mem_address), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_rcount", 32'(record_count), 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run(tab[i], $sformatf("vec%0d", i));

    clear_mem();
    for (int i = 0; i < 70; i++) begin
      k = (16'h3FFE + i) % 16384;
      mem[k] = 16'h0010 + 16'(i);
    end
    collect(14'h3FFE, 0, 0, dc, fv, nr, wr);
    chk("lim_wrap", 32'(wr), 1);
    chk("lim_reads", 32'(nr), 64);
    chk("lim_nbytes", 32'(got.size()), 62);
    if (got.size() == 62) begin
      chk("lim_first", 32'(got[0]), 32'h010);
      chk("lim_tail", 32'(got[61]), 32'h04D);
    end
    k = 0;
    foreach (got[i]) k += int'(got[i][8]);
    chk("lim_no_last", 32'(k), 0);
    chk("lim_error", 32'(error), 1);
    @(negedge clock);

    lim = tab[0];
    load(lim);
    @(negedge clock);
    base_address = lim.base;
    start = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    #1;
    while (!bus.out_valid && k < 50) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk("rst_reach_emit", 32'(bus.out_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.out_valid), 0);
    chk("rst_mid_idle",
        {busy, bus.mem_read, bus.out_last, done},
        4'b0);
    @(negedge clock);
    reset_n = 1'b1;
    run(tab[0], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, fails);
    $finish;
  end

endmodule
